// File: rtl/sweep_ctrl8b_if.sv
`default_nettype none
// ============================================================================
//  Module  : sweep_ctrl8b_if
//  Brief   : Host/datapath bundle for the triangle-sweep controller.
//  Rev     : 1.0  initial release
// ============================================================================
interface sweep_ctrl8b_if #(
    parameter int WIDTH  = 8,
    parameter int TRIP_W = 4
);
    logic              start;
    logic              abort;
    logic [WIDTH-1:0]  lo;
    logic [WIDTH-1:0]  hi;
    logic [TRIP_W-1:0] trips;
    logic [WIDTH-1:0]  count;
    logic              dir;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, abort, lo, hi, trips,
        input  count, dir, busy, done, err
    );

    modport slave (
        input  start, abort, lo, hi, trips,
        output count, dir, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/sweep_ctrl8b.sv
`default_nettype none
// ============================================================================
//  Module  : sweep_ctrl8b
//  Brief   : Drives count as a lo..hi triangle sweep for N round trips.
//  Rev     : 1.0  initial release
// ============================================================================
module sweep_ctrl8b #(
    parameter int WIDTH  = 8,
    parameter int TRIP_W = 4
) (
    input  wire logic        clk,
    input  wire logic        reset,
    sweep_ctrl8b_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  lo_q,    lo_d;
    logic [WIDTH-1:0]  hi_q,    hi_d;
    logic [TRIP_W-1:0] trip_q,  trip_d;
    logic [TRIP_W-1:0] trips_q, trips_d;
    logic              dir_q,   dir_d;
    logic              err_q,   err_d;
    logic [TRIP_W-1:0] w_trip_next;

    assign w_trip_next = trip_q + TRIP_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            trip_q  <= '0;
            trips_q <= '0;
            dir_q   <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            trip_q  <= trip_d;
            trips_q <= trips_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        trip_d  = trip_q;
        trips_d = trips_q;
        dir_d   = dir_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.lo < bus.hi) begin
                        lo_d    = bus.lo;
                        hi_d    = bus.hi;
                        trips_d = bus.trips;
                        trip_d  = '0;
                        count_d = bus.lo;
                        dir_d   = 1'b1;
                        state_d = S_UP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            // Abort outranks the turn check so count freezes where it stood.
            S_UP: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (count_q == hi_q) begin
                    count_d = hi_q - WIDTH'(1);
                    dir_d   = 1'b0;
                    state_d = S_DOWN;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            S_DOWN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (count_q == lo_q) begin
                    // trips==0 never terminates; the trip counter just wraps.
                    if ((trips_q != '0) && (w_trip_next == trips_q)) begin
                        state_d = S_DONE;
                    end else begin
                        trip_d  = w_trip_next;
                        count_d = lo_q + WIDTH'(1);
                        dir_d   = 1'b1;
                        state_d = S_UP;
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.count = count_q;
    assign bus.dir   = dir_q;
    assign bus.busy  = (state_q == S_UP) || (state_q == S_DOWN);
    assign bus.done  = (state_q == S_DONE);
    assign bus.err   = err_q;

endmodule
`default_nettype wire

// File: doc/sweep_ctrl8b.md
# sweep_ctrl8b

Sequencing controller for the 8-bit up/down count datapath: on a start request it drives the count as a triangle sweep between programmable lower and upper bounds for a programmed number of round trips, then reports completion. It owns the count register and direction flag, so downstream logic consumes `count`/`dir` exactly as it would from the plain up/down counter. It sits between a host (start/abort/configuration) and any logic driven by `count`.

## Interface

- `WIDTH`, 8, count and bound width
- `TRIP_W`, 4, width of round-trip count and internal trip counter
- `clk` input 1, rising-edge clock
- `reset` input 1, asynchronous, active-high; clears all state immediately
- `start` input 1, sampled in IDLE only; begins a sweep
- `abort` input 1, sampled in UP/DOWN only; terminates the sweep
- `lo` input WIDTH, lower bound, unsigned, latched on accepted start
- `hi` input WIDTH, upper bound, unsigned, latched on accepted start
- `trips` input TRIP_W, round trips to run; 0 = run until abort; latched on accepted start
- `count` output WIDTH, current count value (registered)
- `dir` output 1, 1 = counting up, 0 = counting down (registered)
- `busy` output 1, high in UP or DOWN
- `done` output 1, one-cycle pulse after the final round trip
- `err` output 1, one-cycle pulse on a rejected start

## Operation

- States: IDLE, UP, DOWN, DONE. `busy`/`done` decode directly from the state register; no input-to-output combinational path.
- Reset: state IDLE, `count`=0, `dir`=1, `busy`=0, `done`=0, `err`=0, trip counter 0, latched bounds 0.
- IDLE: `count` and `dir` hold. On `start`:
  - `lo` < `hi`: latch `lo`, `hi`, `trips`; `count`<=`lo`, `dir`<=1, trip counter<=0, go UP.
  - `lo` >= `hi`: `err`=1 for the next cycle, stay IDLE, `count` unchanged.
  - `abort` ignored in IDLE.
- UP: if `abort`, go IDLE with `count`/`dir` held. Else if `count`==hi_l: `count`<=hi_l-1, `dir`<=0, go DOWN. Else `count`<=`count`+1.
- DOWN: if `abort`, go IDLE with `count`/`dir` held. Else if `count`==lo_l, a round trip is complete:
  - If `trips`!=0 and trip counter+1 == latched `trips`: go DONE with `count` held at lo_l.
  - Otherwise: increment the trip counter, `count`<=lo_l+1, `dir`<=1, go UP.
  - Else `count`<=`count`-1.
- DONE: `done`=1 for this single cycle, `count`/`dir` hold, then go IDLE unconditionally. `start` is ignored in DONE.
- `start` while busy is ignored. Changes to `lo`/`hi`/`trips` while busy have no effect.
- `abort` takes priority over the turn and terminal checks in the same cycle.
- Arithmetic: unsigned, WIDTH bits. Because `lo` < `hi` is enforced, the count never wraps. `lo`=0 and `hi`=2^WIDTH-1 are legal.
- `trips`=0: the trip counter wraps freely and the sweep never terminates without `abort` or `reset`.

## Timing

- Accepted start at edge E0: at E0, `count`=lo, `dir`=1, `busy`=1.
- Each extreme appears for exactly one cycle per turn. One round trip is 2·(hi−lo) cycles, from `count`=lo back to `count`=lo.
- With `trips`=N: the final `count`=lo is reached at edge E0+2N·(hi−lo). At the next edge `done`=1 and `busy`=0, and one cycle later `done`=0.
- A new start is accepted the cycle after DONE at the earliest.
- Abort sampled at edge Ea: at Ea `busy`=0 and `count` is frozen at its pre-Ea value; `done` is never asserted.
- Rejected start at edge E: `err`=1 for the cycle following E only.
- `reset` asserted at any time: outputs go to reset values without waiting for `clk`. The first start can be sampled at the first rising edge after `reset` deasserts.

## Test plan

- Reset then idle: hold `reset` 50 ns, no start → `count`=0, `dir`=1, `busy`=`done`=`err`=0. Pulse `abort` → no change.
- Single trip: `lo`=3, `hi`=6, `trips`=1, pulse `start` → `count` 3,4,5,6,5,4,3 on consecutive cycles; `dir` 1,1,1,1,0,0,0; then `done`=1 for one cycle with `count`=3, `busy`=0; `count` stays 3.
- Narrow multi-trip: `lo`=10, `hi`=11, `trips`=2 → `count` 10,11,10,11,10; `done` pulses at 5 cycles after start. Pulse `start` mid-run → ignored.
- Rejected start: `lo`=`hi`=7 → `err`=1 for exactly one cycle, `busy` stays 0, `count` unchanged. Repeat with `lo`=8, `hi`=7 → same.
- Continuous plus abort: `lo`=0, `hi`=255, `trips`=0; abort when `count`=200 on the down leg → `busy`=0, `count` holds 200, `dir`=0, no `done`. Run 3 full trips before abort → no `done`, no wrap past 0/255.
- Reset mid-run: assert `reset` between clock edges during UP with `count`=5 → `count`=0, `busy`=0 immediately. After release, a fresh start sweeps from the new `lo`.
